// File: rtl/isqrt12.sv
// rtl/isqrt12.sv - 12-bit unsigned integer square root, one restoring digit step per cycle
module isqrt12 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  root,
  output logic [6:0]  rem,
  output logic        exact
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [11:0] opnd_q, opnd_d;
  logic [5:0]  q_q, q_d;
  logic [8:0]  r_q, r_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [5:0]  root_q, root_d;
  logic [6:0]  rem_q, rem_d;
  logic        exact_q, exact_d;

  logic [1:0]  pair;
  logic [8:0]  r_sh;
  logic [7:0]  trial;
  logic        ge;
  logic [8:0]  r_new;
  logic [5:0]  q_new;

  always_comb begin
    // Bring down the next radicand digit pair (index = counter) and try q*4+1.
    pair  = opnd_q[{cnt_q, 1'b0} +: 2];
    r_sh  = {r_q[6:0], pair};
    trial = {q_q, 2'b01};
    ge    = (r_sh >= {1'b0, trial});
    r_new = ge ? (r_sh - {1'b0, trial}) : r_sh;
    q_new = {q_q[4:0], ge};

    state_d = state_q;
    opnd_d  = opnd_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    root_d  = root_q;
    rem_d   = rem_q;
    exact_d = exact_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opnd_d  = x;
          q_d     = 6'd0;
          r_d     = 9'd0;
          cnt_d   = 3'd5;
          state_d = CALC;
        end
      end
      CALC: begin
        q_d = q_new;
        r_d = r_new;
        if (cnt_q == 3'd0) begin
          root_d  = q_new;
          rem_d   = r_new[6:0];
          exact_d = (r_new == 9'd0);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opnd_q  <= 12'd0;
      q_q     <= 6'd0;
      r_q     <= 9'd0;
      cnt_q   <= 3'd0;
      root_q  <= 6'd0;
      rem_q   <= 7'd0;
      exact_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      exact_q <= exact_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign root      = root_q;
  assign rem       = rem_q;
  assign exact     = exact_q;

endmodule
